// File: rtl/alu_operand_loader_if.sv
// alu_operand_loader_if: switch/button inputs and registered operand outputs of the operand loader
interface alu_operand_loader_if #(
    parameter int N_BITS = 8,
    parameter int NB_OP  = 6
);
    logic [N_BITS-1:0] SW;
    logic              BTN_A;
    logic              BTN_B;
    logic              BTN_OP;
    logic [N_BITS-1:0] A;
    logic [N_BITS-1:0] B;
    logic [NB_OP-1:0]  OP;
    logic              VALID;
    logic [1:0]        STATE;
    modport master (output SW, BTN_A, BTN_B, BTN_OP, input A, B, OP, VALID, STATE);
    modport slave  (input SW, BTN_A, BTN_B, BTN_OP, output A, B, OP, VALID, STATE);
endinterface

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: debounced pushbutton capture of operands A, B and opcode in enforced order
module alu_operand_loader #(
    parameter int N_BITS          = 8,
    parameter int NB_OP           = 6,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    alu_operand_loader_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    typedef enum logic [1:0] {S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_READY} state_t;
    state_t            state_q, state_d;
    logic [2:0]        btn, s1_q, s2_q, deb_q, deb_d, deb_prev_q, press_q, press_d;
    logic [CW-1:0]     cnt_q [3];
    logic [CW-1:0]     cnt_d [3];
    logic [N_BITS-1:0] a_q, a_d, b_q, b_d;
    logic [NB_OP-1:0]  op_q, op_d;
    logic              valid_q, valid_d;
    assign btn = {bus.BTN_OP, bus.BTN_B, bus.BTN_A};
    // Bit 0 = A, 1 = B, 2 = OP for every per-button vector
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1))
                    deb_d[i] = s2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        press_d = deb_q & ~deb_prev_q;
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            S_WAIT_A: if (press_q[0]) begin
                a_d     = bus.SW;
                state_d = S_WAIT_B;
            end
            S_WAIT_B: if (press_q[1]) begin
                b_d     = bus.SW;
                state_d = S_WAIT_OP;
            end
            S_WAIT_OP: if (press_q[2]) begin
                op_d    = bus.SW[NB_OP-1:0];
                state_d = S_READY;
            end
            default: begin
                // A restarts the sequence; B/OP reload in place, lower priority dropped
                if (press_q[0]) begin
                    a_d     = bus.SW;
                    state_d = S_WAIT_B;
                end else if (press_q[1]) begin
                    b_d = bus.SW;
                end else if (press_q[2]) begin
                    op_d = bus.SW[NB_OP-1:0];
                end
            end
        endcase
        valid_d = (state_d == S_READY);
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            state_q    <= S_WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            s1_q       <= btn;
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            press_q    <= press_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            valid_q    <= valid_d;
        end
    end
    assign bus.A     = a_q;
    assign bus.B     = b_q;
    assign bus.OP    = op_q;
    assign bus.VALID = valid_q;
    assign bus.STATE = state_q;
endmodule
